// File: rtl/snoop_responder.sv
`default_nettype none
// ============================================================================
// Module   : snoop_responder
// Purpose  : MSI snoop engine for one processor cache. Qualifying bus reads
//            and read-exclusives from other requesters are queued (2 deep),
//            looked up against a local line table, and answered by flushing
//            modified data and/or downgrading/invalidating the line.
// Ports    : clk, rst_n       - clock, synchronous active-low reset
//            bus_wire[10:0]   - snooped word {src, cmd, addr, data}
//            loc_we/addr/state/data - processor-side line table write
//            flush_gnt        - bus grant for a pending flush
//            flush_req        - flush request (held while in FLUSH)
//            flush_bus[10:0]  - flush word, driven only in the grant cycle
//            inval            - pulse when a snoop moves a line to I
//            snoop_busy       - engine active or queue non-empty
//            ovf              - sticky snoop queue overflow
//            conflict         - pulse when a local write loses to a snoop
// Revision : 1.0 - initial release
// ============================================================================
module snoop_responder #(
  parameter logic [1:0] MY_ID = 2'b01,
  parameter int         LINES = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [10:0] bus_wire,
  input  logic        loc_we,
  input  logic [2:0]  loc_addr,
  input  logic [1:0]  loc_state,
  input  logic [3:0]  loc_data,
  input  logic        flush_gnt,
  output logic        flush_req,
  output logic [10:0] flush_bus,
  output logic        inval,
  output logic        snoop_busy,
  output logic        ovf,
  output logic        conflict
);

  localparam int         AW       = 3;
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LOOKUP = 2'd1;
  localparam logic [1:0] S_FLUSH  = 2'd2;
  localparam logic [1:0] S_UPDATE = 2'd3;

  localparam logic [1:0] CMD_RD    = 2'b01;
  localparam logic [1:0] CMD_RDX   = 2'b10;
  localparam logic [1:0] CMD_FLUSH = 2'b11;

  localparam logic [1:0] ST_I = 2'b00;
  localparam logic [1:0] ST_S = 2'b01;
  localparam logic [1:0] ST_M = 2'b10;

  // Bus word fields; the snooped data nibble carries no meaning for us.
  logic [1:0]    w_src, w_cmd;
  logic [AW-1:0] w_addr;
  logic [3:0]    w_unused_bus_data;
  assign w_src             = bus_wire[10:9];
  assign w_cmd             = bus_wire[8:7];
  assign w_addr            = bus_wire[6:4];
  assign w_unused_bus_data = bus_wire[3:0];

  logic [1:0]          state_q, state_d;
  logic [1:0][4:0]     q_mem_q, q_mem_d;   // entry = {cmd, addr}, [0] is head
  logic [1:0]          q_cnt_q, q_cnt_d;
  logic [1:0]          wk_cmd_q;
  logic [AW-1:0]       wk_addr_q;
  logic [1:0]          snap_q;             // line state captured in LOOKUP
  logic                ovf_q;
  logic [1:0]          tbl_st_q  [LINES];
  logic [3:0]          tbl_dat_q [LINES];

  logic          w_qual, w_pop, w_push_ok, w_drop, w_loc_hit;
  logic [1:0]    w_rd_st, w_new_st, w_loc_st;
  logic [3:0]    w_rd_dat;

  assign w_qual    = ((w_cmd == CMD_RD) || (w_cmd == CMD_RDX)) &&
                     (w_src != 2'b00) && (w_src != MY_ID);
  assign w_pop     = (state_q == S_IDLE) && (q_cnt_q != 2'd0);
  // A full queue still accepts the word when the head leaves this cycle.
  assign w_push_ok = w_qual && ((q_cnt_q != 2'd2) || w_pop);
  assign w_drop    = w_qual && (q_cnt_q == 2'd2) && !w_pop;

  assign w_rd_st   = tbl_st_q[wk_addr_q];
  assign w_rd_dat  = tbl_dat_q[wk_addr_q];
  // UPDATE works from the LOOKUP snapshot, not a fresh table read.
  assign w_new_st  = ((snap_q == ST_M) && (wk_cmd_q == CMD_RD)) ? ST_S : ST_I;
  assign w_loc_hit = (state_q == S_UPDATE) && loc_we && (loc_addr == wk_addr_q);
  assign w_loc_st  = (loc_state == 2'b11) ? ST_I : loc_state;

  // Snoop queue next state: pop shifts the tail forward, push lands behind it.
  always_comb begin
    q_mem_d = q_mem_q;
    q_cnt_d = q_cnt_q;
    if (w_pop) begin
      q_mem_d[0] = q_mem_q[1];
      q_cnt_d    = q_cnt_q - 2'd1;
    end
    if (w_push_ok) begin
      q_mem_d[q_cnt_d[0]] = {w_cmd, w_addr};
      q_cnt_d             = q_cnt_d + 2'd1;
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (q_cnt_q != 2'd0) state_d = S_LOOKUP;
      S_LOOKUP: begin
        if (w_rd_st == ST_M)                              state_d = S_FLUSH;
        else if ((w_rd_st == ST_S) && (wk_cmd_q == CMD_RDX)) state_d = S_UPDATE;
        else                                              state_d = S_IDLE;
      end
      S_FLUSH:  if (flush_gnt) state_d = S_UPDATE;
      S_UPDATE: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    flush_req  = (state_q == S_FLUSH);
    flush_bus  = '0;
    if ((state_q == S_FLUSH) && flush_gnt)
      flush_bus = {MY_ID, CMD_FLUSH, wk_addr_q, w_rd_dat};
    inval      = (state_q == S_UPDATE) && (w_new_st == ST_I);
    conflict   = w_loc_hit;
    snoop_busy = (state_q != S_IDLE) || (q_cnt_q != 2'd0);
    ovf        = ovf_q;
  end

  // Queue, working registers and line table
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_mem_q   <= '0;
      q_cnt_q   <= 2'd0;
      wk_cmd_q  <= 2'd0;
      wk_addr_q <= '0;
      snap_q    <= ST_I;
      ovf_q     <= 1'b0;
      for (int i = 0; i < LINES; i++) begin
        tbl_st_q[i]  <= ST_I;
        tbl_dat_q[i] <= 4'd0;
      end
    end else begin
      q_mem_q <= q_mem_d;
      q_cnt_q <= q_cnt_d;
      if (w_pop) begin
        wk_cmd_q  <= q_mem_q[0][4:3];
        wk_addr_q <= q_mem_q[0][2:0];
      end
      if (state_q == S_LOOKUP) snap_q <= w_rd_st;
      if (w_drop)              ovf_q  <= 1'b1;
      for (int i = 0; i < LINES; i++) begin
        if (loc_we && (loc_addr == AW'(i)) && !w_loc_hit) begin
          tbl_st_q[i]  <= w_loc_st;
          tbl_dat_q[i] <= loc_data;
        end
        if ((state_q == S_UPDATE) && (wk_addr_q == AW'(i)))
          tbl_st_q[i] <= w_new_st;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_snoop_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_snoop_responder
// Purpose  : Self-checking bench for snoop_responder: directed vector table,
//            hand sequences for overflow and reset-in-FLUSH, and random
//            traffic checked against a transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_snoop_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [10:0] bus_wire;
  logic        loc_we;
  logic [2:0]  loc_addr;
  logic [1:0]  loc_state;
  logic [3:0]  loc_data;
  logic        flush_gnt;
  logic        flush_req;
  logic [10:0] flush_bus;
  logic        inval;
  logic        snoop_busy;
  logic        ovf;
  logic        conflict;

  snoop_responder #(.MY_ID(2'b01), .LINES(8)) dut (
    .clk(clk), .rst_n(rst_n), .bus_wire(bus_wire), .loc_we(loc_we),
    .loc_addr(loc_addr), .loc_state(loc_state), .loc_data(loc_data),
    .flush_gnt(flush_gnt), .flush_req(flush_req), .flush_bus(flush_bus),
    .inval(inval), .snoop_busy(snoop_busy), .ovf(ovf), .conflict(conflict)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [10:0] bw(input logic [1:0] s, input logic [1:0] c,
                                     input logic [2:0] a, input logic [3:0] d);
    return {s, c, a, d};
  endfunction

  task automatic drive(input logic r, input logic we, input logic [2:0] la,
                       input logic [1:0] ls, input logic [3:0] ld,
                       input logic [10:0] bus, input logic gnt);
    rst_n = r; loc_we = we; loc_addr = la; loc_state = ls; loc_data = ld;
    bus_wire = bus; flush_gnt = gnt;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(1'b0, 0, 0, 0, 0, 0, 0);
    step(); step();
    drive(1'b1, 0, 0, 0, 0, 0, 0);
  endtask

  // Waits (bounded) until flush_req is seen at a negedge; leaves time just
  // after that negedge so the caller continues from the FLUSH cycle.
  task automatic wait_req(input string nm);
    bit seen = 0;
    for (int k = 0; k < 12 && !seen; k++) begin
      @(negedge clk);
      if (flush_req === 1'b1) seen = 1;
      else step();
    end
    chk(nm, {31'd0, seen}, 32'd1);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        we;
    logic [2:0]  la;
    logic [1:0]  ls;
    logic [3:0]  ld;
    logic [10:0] bus;
    logic        gnt;
    logic        e_req;
    logic [10:0] e_fbus;
    logic        e_inv;
    logic        e_conf;
    logic        e_busy;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(input logic we, input logic [2:0] la, input logic [1:0] ls,
                              input logic [3:0] ld, input logic [10:0] bus, input logic gnt,
                              input logic req, input logic [10:0] fb, input logic inv,
                              input logic cf, input logic busy);
    vec_t v;
    v.we = we; v.la = la; v.ls = ls; v.ld = ld; v.bus = bus; v.gnt = gnt;
    v.e_req = req; v.e_fbus = fb; v.e_inv = inv; v.e_conf = cf; v.e_busy = busy;
    return v;
  endfunction

  // ---------------- reference model ----------------
  // A job moves through named phases; the table and queue are plain arrays.
  localparam int PH_NONE = 0, PH_LOOK = 1, PH_FLUSH = 2, PH_UPD = 3;
  logic [1:0] m_st  [8];
  logic [3:0] m_dat [8];
  logic [4:0] m_q[$];
  bit         m_ovf;
  int         m_ph;
  logic [1:0] m_cmd, m_snap;
  logic [2:0] m_addr;

  task automatic m_reset();
    for (int i = 0; i < 8; i++) begin m_st[i] = 2'd0; m_dat[i] = 4'd0; end
    m_q.delete(); m_ovf = 0; m_ph = PH_NONE; m_cmd = 0; m_snap = 0; m_addr = 0;
  endtask

  task automatic m_check_and_advance();
    logic        e_busy, e_req, e_inv, e_conf;
    logic [10:0] e_fbus;
    logic [1:0]  newst;
    bit          drop_loc, qual;
    int          ph0;
    newst  = (m_snap == 2'b10 && m_cmd == 2'b01) ? 2'b01 : 2'b00;
    e_busy = (m_ph != PH_NONE) || (m_q.size() > 0);
    e_req  = (m_ph == PH_FLUSH);
    e_fbus = (m_ph == PH_FLUSH && flush_gnt) ? {2'b01, 2'b11, m_addr, m_dat[m_addr]} : 11'd0;
    e_inv  = (m_ph == PH_UPD) && (newst == 2'b00);
    e_conf = (m_ph == PH_UPD) && loc_we && (loc_addr == m_addr);
    chk("rnd_busy", {31'd0, snoop_busy}, {31'd0, e_busy});
    chk("rnd_req", {31'd0, flush_req}, {31'd0, e_req});
    chk("rnd_fbus", {21'd0, flush_bus}, {21'd0, e_fbus});
    chk("rnd_inval", {31'd0, inval}, {31'd0, e_inv});
    chk("rnd_conflict", {31'd0, conflict}, {31'd0, e_conf});
    chk("rnd_ovf", {31'd0, ovf}, {31'd0, m_ovf});
    // advance one clock
    ph0 = m_ph;
    drop_loc = e_conf;
    case (ph0)
      PH_LOOK: begin
        m_snap = m_st[m_addr];
        if (m_st[m_addr] == 2'b10)                         m_ph = PH_FLUSH;
        else if (m_st[m_addr] == 2'b01 && m_cmd == 2'b10) m_ph = PH_UPD;
        else                                               m_ph = PH_NONE;
      end
      PH_FLUSH: if (flush_gnt) m_ph = PH_UPD;
      PH_UPD: begin m_st[m_addr] = newst; m_ph = PH_NONE; end
      default: ;
    endcase
    if (loc_we && !drop_loc) begin
      m_st[loc_addr]  = (loc_state == 2'b11) ? 2'b00 : loc_state;
      m_dat[loc_addr] = loc_data;
    end
    if (ph0 == PH_NONE && m_q.size() > 0) begin
      {m_cmd, m_addr} = m_q.pop_front();
      m_ph = PH_LOOK;
    end
    qual = (bus_wire[8:7] == 2'b01 || bus_wire[8:7] == 2'b10) &&
           bus_wire[10:9] != 2'b00 && bus_wire[10:9] != 2'b01;
    if (qual) begin
      if (m_q.size() < 2) m_q.push_back(bus_wire[8:4]);
      else                m_ovf = 1;
    end
  endtask

  initial begin
    drive(1'b0, 0, 0, 0, 0, 0, 0);
    do_reset();

    // ---- table: S-line invalidate, M-line flush, filtering, conflict ----
    tv.push_back(mk(0,0,0,0,0,0,             0,0,0,0,0)); // reset state
    tv.push_back(mk(1,3,1,4'h5,0,0,          0,0,0,0,0));
    tv.push_back(mk(0,0,0,0,bw(2,2,3,0),0,   0,0,0,0,0)); // N
    tv.push_back(mk(0,0,0,0,0,0,             0,0,0,0,1));
    tv.push_back(mk(0,0,0,0,0,0,             0,0,0,0,1)); // LOOKUP
    tv.push_back(mk(0,0,0,0,0,0,             0,0,1,0,1)); // N+3 inval
    tv.push_back(mk(0,0,0,0,0,0,             0,0,0,0,0));
    tv.push_back(mk(0,0,0,0,bw(2,2,3,0),0,   0,0,0,0,0)); // line 3 now I
    tv.push_back(mk(0,0,0,0,0,0,             0,0,0,0,1));
    tv.push_back(mk(0,0,0,0,0,0,             0,0,0,0,1));
    tv.push_back(mk(0,0,0,0,0,0,             0,0,0,0,0)); // no update
    tv.push_back(mk(1,2,2,4'hA,0,0,          0,0,0,0,0));
    tv.push_back(mk(0,0,0,0,bw(3,1,2,0),0,   0,0,0,0,0)); // N
    tv.push_back(mk(0,0,0,0,0,0,             0,0,0,0,1));
    tv.push_back(mk(0,0,0,0,0,0,             0,0,0,0,1));
    tv.push_back(mk(0,0,0,0,0,0,             1,0,0,0,1)); // FLUSH from N+3
    tv.push_back(mk(0,0,0,0,0,0,             1,0,0,0,1));
    tv.push_back(mk(0,0,0,0,0,1,             1,11'h3AA,0,0,1)); // grant
    tv.push_back(mk(0,0,0,0,0,0,             0,0,0,0,1)); // UPDATE M->S
    tv.push_back(mk(0,0,0,0,0,1,             0,0,0,0,0)); // stray grant ignored
    tv.push_back(mk(0,0,0,0,bw(2,2,2,0),0,   0,0,0,0,0)); // line 2 is S
    tv.push_back(mk(0,0,0,0,0,0,             0,0,0,0,1));
    tv.push_back(mk(0,0,0,0,0,0,             0,0,0,0,1));
    tv.push_back(mk(0,0,0,0,0,0,             0,0,1,0,1));
    tv.push_back(mk(0,0,0,0,bw(1,1,5,0),0,   0,0,0,0,0)); // own ID
    tv.push_back(mk(0,0,0,0,bw(0,2,5,0),0,   0,0,0,0,0)); // src 00
    tv.push_back(mk(0,0,0,0,bw(2,0,5,0),0,   0,0,0,0,0)); // idle cmd
    tv.push_back(mk(0,0,0,0,bw(2,3,5,0),0,   0,0,0,0,0)); // flush cmd
    tv.push_back(mk(0,0,0,0,0,0,             0,0,0,0,0));
    tv.push_back(mk(1,4,1,4'h7,0,0,          0,0,0,0,0));
    tv.push_back(mk(0,0,0,0,bw(2,2,4,0),0,   0,0,0,0,0));
    tv.push_back(mk(0,0,0,0,0,0,             0,0,0,0,1));
    tv.push_back(mk(0,0,0,0,0,0,             0,0,0,0,1));
    tv.push_back(mk(1,4,2,4'hF,0,0,          0,0,1,1,1)); // conflict
    tv.push_back(mk(0,0,0,0,0,0,             0,0,0,0,0));
    tv.push_back(mk(0,0,0,0,bw(2,1,4,0),0,   0,0,0,0,0)); // line 4 must be I
    tv.push_back(mk(0,0,0,0,0,0,             0,0,0,0,1));
    tv.push_back(mk(0,0,0,0,0,0,             0,0,0,0,1));
    tv.push_back(mk(0,0,0,0,0,0,             0,0,0,0,0)); // no FLUSH

    foreach (tv[i]) begin
      drive(1'b1, tv[i].we, tv[i].la, tv[i].ls, tv[i].ld, tv[i].bus, tv[i].gnt);
      @(negedge clk);
      chk($sformatf("vec%0d_req", i),  {31'd0, flush_req},  {31'd0, tv[i].e_req});
      chk($sformatf("vec%0d_fbus", i), {21'd0, flush_bus},  {21'd0, tv[i].e_fbus});
      chk($sformatf("vec%0d_inv", i),  {31'd0, inval},      {31'd0, tv[i].e_inv});
      chk($sformatf("vec%0d_conf", i), {31'd0, conflict},   {31'd0, tv[i].e_conf});
      chk($sformatf("vec%0d_busy", i), {31'd0, snoop_busy}, {31'd0, tv[i].e_busy});
      chk($sformatf("vec%0d_ovf", i),  {31'd0, ovf},        32'd0);
      step();
    end

    // ---- overflow while parked in FLUSH ----
    do_reset();
    drive(1'b1, 1, 1, 2, 4'h3, 0, 0);           step();
    drive(1'b1, 0, 0, 0, 0, bw(2,1,1,0), 0);    step();
    drive(1'b1, 0, 0, 0, 0, 0, 0);
    wait_req("ovf_reach_flush");
    step();
    drive(1'b1, 0, 0, 0, 0, bw(2,2,5,0), 0);    step();
    drive(1'b1, 0, 0, 0, 0, bw(3,2,6,0), 0);    step();
    @(negedge clk);
    chk("ovf_two_queued", {31'd0, ovf}, 32'd0);
    drive(1'b1, 0, 0, 0, 0, bw(2,1,7,0), 0);    step();
    drive(1'b1, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("ovf_third_dropped", {31'd0, ovf}, 32'd1);
    step(); step();
    drive(1'b1, 0, 0, 0, 0, 0, 1);              step();
    drive(1'b1, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 12; k++) step();
    @(negedge clk);
    chk("ovf_sticky", {31'd0, ovf}, 32'd1);
    chk("ovf_drained", {31'd0, snoop_busy}, 32'd0);
    do_reset();
    @(negedge clk);
    chk("ovf_cleared", {31'd0, ovf}, 32'd0);

    // ---- reset during FLUSH ----
    step();
    drive(1'b1, 1, 6, 2, 4'h9, 0, 0);           step();
    drive(1'b1, 0, 0, 0, 0, bw(2,2,6,0), 0);    step();
    drive(1'b1, 0, 0, 0, 0, 0, 0);
    wait_req("rst_reach_flush");
    step();
    drive(1'b0, 0, 0, 0, 0, 0, 0);              step();
    drive(1'b1, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("rst_flush_req", {31'd0, flush_req}, 32'd0);
    chk("rst_busy", {31'd0, snoop_busy}, 32'd0);
    chk("rst_fbus", {21'd0, flush_bus}, 32'd0);
    begin
      bit act = 0;
      step();
      drive(1'b1, 0, 0, 0, 0, bw(2,2,6,0), 1);  step();
      drive(1'b1, 0, 0, 0, 0, 0, 1);
      for (int k = 0; k < 6; k++) begin
        @(negedge clk);
        if (flush_req || inval || (flush_bus != 0)) act = 1;
        step();
      end
      chk("rst_line6_invalid", {31'd0, act}, 32'd0);
    end

    // ---- randomized traffic against the reference model ----
    do_reset();
    m_reset();
    for (int c = 0; c < 3000; c++) begin
      logic [10:0] b;
      b = ($urandom_range(0, 9) < 4) ? 11'($urandom) : 11'd0;
      drive(1'b1, ($urandom_range(0, 3) == 0), 3'($urandom), 2'($urandom),
            4'($urandom), b, ($urandom_range(0, 2) == 0));
      @(negedge clk);
      m_check_and_advance();
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/snoop_responder.md
SNOOP_RESPONDER -- requirements
Module: snoop_responder

Interface
REQ-001 Parameter: MY_ID, 2'b01, requester ID of the owning processor; bus transactions carrying this ID are not snooped.
REQ-002 Parameter: LINES, 8, number of cache lines tracked; the address field is 3 bits.
REQ-003 Port: clk  input  1  single clock; all state changes on its rising edge.
REQ-004 Port: rst_n  input  1  reset, synchronous, active-low.
REQ-005 Port: bus_wire  input  11  snooped bus word: [10:9] src ID, [8:7] cmd (00 idle, 01 BusRd, 10 BusRdX, 11 Flush), [6:4] addr, [3:0] data.
REQ-006 Port: loc_we  input  1  processor-side line update strobe.
REQ-007 Port: loc_addr  input  3  line index for loc_we.
REQ-008 Port: loc_state  input  2  MSI state to write (00 I, 01 S, 10 M; 11 stored as I).
REQ-009 Port: loc_data  input  4  line data to write.
REQ-010 Port: flush_gnt  input  1  bus grant for a pending flush.
REQ-011 Port: flush_req  output  1  request for the bus to write back a modified line.
REQ-012 Port: flush_bus  output  11  flush word; zero when not granted.
REQ-013 Port: inval  output  1  one-cycle pulse when a line leaves S or M because of a snoop.
REQ-014 Port: snoop_busy  output  1  high whenever the FSM is not in IDLE or the queue is non-empty.
REQ-015 Port: ovf  output  1  sticky flag set on snoop queue overflow.
REQ-016 Port: conflict  output  1  one-cycle pulse when a local write is dropped by REQ-029.

Function
REQ-017 Internal line table: LINES entries of {state[1:0], data[3:0]}, written by loc_we when the snoop FSM is not updating the same index.
REQ-018 Qualifying snoop: cmd in {01, 10}, src != 00, and src != MY_ID; idle and Flush words are not queued.
REQ-019 Snoop queue: 2-entry FIFO of {cmd, addr}; a qualifying snoop is pushed in the cycle it appears on bus_wire.
REQ-020 Push when full: the word is dropped and ovf is set (sticky until reset); a push and pop in the same cycle when full are accepted.
REQ-021 FSM states: IDLE, LOOKUP, FLUSH, UPDATE.
REQ-022 IDLE -> LOOKUP when the queue is non-empty; the head entry is popped into a working register on that edge.
REQ-023 LOOKUP, one cycle, reads the table entry at the working address:
- M with BusRd or BusRdX -> FLUSH.
- S with BusRdX -> UPDATE.
- Any other combination -> IDLE, with no table change.
REQ-024 FLUSH: flush_req = 1 and is held until flush_gnt is sampled high. In the grant cycle, flush_bus = {MY_ID, 2'b11, addr, line data}. The FSM then moves to UPDATE.
REQ-025 UPDATE, one cycle:
- M with BusRd -> S.
- M with BusRdX -> I.
- S with BusRdX -> I.
- inval = 1 only if the new state is I.
- The FSM then returns to IDLE.
REQ-026 Latency: a snoop on bus_wire in cycle N against an idle engine with an S line invalidates it in cycle N+3 (table updated at the end of UPDATE); inval is high in cycle N+3.
REQ-027 An M-line flush asserts flush_req from cycle N+3; a grant in cycle G gives table update and inval at G+1.
REQ-028 flush_bus is all zeros and flush_req is 0 outside FLUSH.
REQ-029 In UPDATE, a loc_we to the same index is dropped and conflict = 1; the snoop result wins. A loc_we to a different index is applied normally.
REQ-030 A loc_we landing while the engine is in LOOKUP or FLUSH for the same index is applied. UPDATE then uses the state sampled in LOOKUP and does not re-read the table.
REQ-031 flush_gnt while not in FLUSH is ignored.

Reset
REQ-032 While rst_n = 0 at a clk edge, the following are cleared: FSM to IDLE, queue empty, every table entry to {I, 0}, ovf, flush_req, flush_bus, inval, conflict, snoop_busy.
REQ-033 Reset asserted in FLUSH or UPDATE aborts the operation, emits no flush word, and makes no table change.

Verification
REQ-034 loc_we addr 3 state S data 5; bus {10,10,3,0} -> inval = 1 three cycles later; table[3] = I; flush_req never asserted.
REQ-035 loc_we addr 2 state M data A; bus {11,01,2,0}; flush_gnt two cycles after flush_req -> flush_bus = {01,11,010,1010} for one cycle; table[2] = S; inval = 0.
REQ-036 Bus word with src = MY_ID, or src = 00, or cmd = 00 -> nothing queued; snoop_busy stays 0.
REQ-037 Three back-to-back qualifying snoops with flush_gnt held low while the engine sits in FLUSH -> third word dropped, ovf = 1 and stays 1 until rst_n.
REQ-038 loc_we to the same index in the UPDATE cycle -> conflict pulse; table holds the snoop result.
REQ-039 rst_n low during FLUSH -> next cycle flush_req = 0, snoop_busy = 0, all lines I.
